fft_reorder_pingpong: RTL
=========================

# fft_reorder_pingpong

Ping-pong output reorder buffer for the radix-2 pipelined FFT: accepts one frame of 2^N complex samples per pass, indexed by the FFT's output counter, and streams each completed frame out in bit-reversed (natural-frequency) or natural address order. Two RAM banks let one frame be written while the previous one is read, so back-to-back frames stream without gaps. A valid/ready output port absorbs downstream stalls; input-side drops are flagged.

## Interface
- WIDTH, 16, bits per real/imag component (signed)
- N, 6, log2 of frame length; frame = 2^N samples; legal 2..12

- clk  in  1  clock, rising edge
- areset  in  1  asynchronous reset, active low
- in_valid  in  1  input sample present this cycle
- in_cnt  in  N  input sample index, 0..2^N-1, increments per valid sample
- in_re, in_im  in  WIDTH  signed input sample
- bitrev_en  in  1  1: bit-reversed read order; 0: natural order
- out_ready  in  1  downstream accepts sample
- out_valid  out  1  output sample valid
- out_idx  out  N  read-sequence index 0..2^N-1 (frequency bin when bitrev_en=1)
- out_re, out_im  out  WIDTH  signed output sample
- out_last  out  1  high with the sample where out_idx = 2^N-1
- overflow  out  1  sticky: an input sample was dropped
- busy  out  1  any bank full or read in progress

## Operation
- Storage: two banks, each 2^N words of 2*WIDTH bits, single-cycle synchronous read.
- Write side: pointer wsel (reset 0). On in_valid with bank[wsel] not full: write {in_re,in_im} at address in_cnt. If in_cnt = 2^N-1: set full[wsel], toggle wsel.
- in_valid while bank[wsel] full: sample dropped, overflow set, wsel unchanged. overflow cleared only by reset.
- Read FSM, states IDLE, READ:
  - IDLE: if full[rsel], latch bitrev_en into mode, rd_cnt = 0, go READ.
  - READ: issue address (mode ? bitrev_N(rd_cnt) : rd_cnt) whenever the output slot is empty or being consumed this cycle; then rd_cnt++. After issuing rd_cnt = 2^N-1: clear full[rsel], toggle rsel; if full of the new rsel, restart READ with rd_cnt = 0 and re-latched mode in the same cycle (no bubble), else IDLE.
- bitrev_N: addr[N-1-i] = rd_cnt[i], i = 0..N-1, for any N.
- Output: out_idx = rd_cnt of the sample presented. Data, out_idx and out_last held stable while out_valid & !out_ready. No sample lost or duplicated across stalls (skid storage as required).
- out_re/out_im forced 0 when out_valid low.
- Set and clear of full[] on the same cycle always target different banks; both take effect.
- bitrev_en changes mid-frame have no effect until the next frame start.

## Timing
- Reset values: out_valid 0, out_idx 0, out_re/out_im 0, out_last 0, overflow 0, busy 0, wsel 0, rsel 0, full[] 0, FSM IDLE.
- Reset mid-operation: all partial and pending frames discarded; first frame after reset goes to bank 0.
- Latency, out_ready held high: last input sample at edge T -> full visible after T -> first address issued at T+1 -> out_valid high after edge T+2 (2 cycles).
- Throughput: 1 sample/cycle each side; continuous input with out_ready high never overflows.
- overflow asserts the cycle after the dropped sample's edge.

## Configuration
- FFT_REORDER_OUTREG_EN defined: extra register stage on out_re/out_im/out_idx/out_last/out_valid; latency 3 cycles; handshake and ordering unchanged.
- Undefined: RAM output drives the output path directly; latency 2 cycles.

## Test plan
- N=6, bitrev_en=1, one frame in_re=k, in_im=-k for in_cnt=k -> 64 outputs, out_idx=j carries re=bitrev6(j) (j=1 -> 32, j=2 -> 16), out_last only at j=63, first out_valid 2 cycles after last input.
- Three back-to-back frames, out_ready=1 -> 192 contiguous out_valid cycles, no gap at frame boundaries, overflow stays 0.
- bitrev_en=0 -> out_re = out_idx for all 64; toggle bitrev_en mid-read -> current frame order unchanged, next frame in new mode.
- out_ready held low for 200 cycles while 3 frames arrive -> third frame dropped, overflow=1; on release, frames 1 and 2 stream intact in order.
- Random out_ready stalls (50%) on 4 frames, input sparse enough to avoid overflow -> every sample delivered once, in order, stable during stall.
- Assert areset mid-input frame and mid-read -> all outputs at reset values; next full frame reads back correctly from bank 0.

Source files
------------

// File: rtl/fft_reorder_pingpong.sv
// Ping-pong reorder buffer for the pipelined radix-2 FFT output: write one frame while the other is read.
// Define FFT_REORDER_OUTREG_EN to add a registered output stage (latency 3 instead of 2).
module fft_reorder_pingpong #(
    parameter int WIDTH = 16,
    parameter int N     = 6
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_cnt,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             bitrev_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_idx,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last,
    output logic             overflow,
    output logic             busy
);

    localparam int           DEPTH = 1 << N;
    localparam logic [N-1:0] LAST  = {N{1'b1}};

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[N-1-i] = a[i];
        return r;
    endfunction

    state_t                  state, state_nxt;
    logic [N-1:0]            rd_cnt, rd_cnt_nxt, rd_addr;
    logic                    mode, mode_nxt;
    logic                    rsel, rsel_nxt, wsel;
    logic [1:0]              full, full_nxt;
    logic                    wr_ok, set_en, clr_en, issue, slot_free, take_p1;

    logic [2*WIDTH-1:0]      bank0 [DEPTH];
    logic [2*WIDTH-1:0]      bank1 [DEPTH];
    logic [2*WIDTH-1:0]      rd0_p1, rd1_p1;
    logic                    bank_p1, vld_p1, last_p1;
    logic [N-1:0]            idx_p1;
    logic signed [WIDTH-1:0] re_p1, im_p1;

    // A bank being released by the final read this cycle may take its first write on the same edge;
    // that read targets address LAST, so only a frame starting at LAST could collide.
    assign wr_ok  = in_valid && (!full[wsel] || (clr_en && (rsel == wsel)));
    assign set_en = wr_ok && (in_cnt == LAST);

    assign slot_free = !vld_p1 || take_p1;
    assign issue     = (state == READ) && slot_free;
    assign clr_en    = issue && (rd_cnt == LAST);
    assign rd_addr   = mode ? bitrev(rd_cnt) : rd_cnt;

    assign full_nxt[0] = (full[0] & ~(clr_en & ~rsel)) | (set_en & ~wsel);
    assign full_nxt[1] = (full[1] & ~(clr_en &  rsel)) | (set_en &  wsel);

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        mode_nxt   = mode;
        rsel_nxt   = rsel;
        case (state)
            IDLE: begin
                if (full[rsel]) begin
                    state_nxt  = READ;
                    rd_cnt_nxt = '0;
                    mode_nxt   = bitrev_en;
                end
            end
            READ: begin
                if (issue) begin
                    if (rd_cnt == LAST) begin
                        rsel_nxt   = ~rsel;
                        rd_cnt_nxt = '0;
                        if (full[~rsel]) mode_nxt  = bitrev_en;
                        else             state_nxt = IDLE;
                    end else begin
                        rd_cnt_nxt = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            mode     <= 1'b0;
            rsel     <= 1'b0;
            wsel     <= 1'b0;
            full     <= '0;
            overflow <= 1'b0;
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            last_p1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_cnt <= rd_cnt_nxt;
            mode   <= mode_nxt;
            rsel   <= rsel_nxt;
            full   <= full_nxt;
            if (set_en) wsel <= ~wsel;
            if (in_valid && !wr_ok) overflow <= 1'b1;
            if (issue) begin
                vld_p1  <= 1'b1;
                idx_p1  <= rd_cnt;
                last_p1 <= (rd_cnt == LAST);
            end else if (take_p1) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Stage p1: synchronous RAM read; the read register only advances on issue so it holds under stall
    always_ff @(posedge clk) begin
        if (wr_ok && !wsel) bank0[in_cnt] <= {in_re, in_im};
        if (issue)          rd0_p1 <= bank0[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_ok && wsel) bank1[in_cnt] <= {in_re, in_im};
        if (issue)         rd1_p1 <= bank1[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (issue) bank_p1 <= rsel;
    end

    assign re_p1 = bank_p1 ? rd1_p1[2*WIDTH-1:WIDTH] : rd0_p1[2*WIDTH-1:WIDTH];
    assign im_p1 = bank_p1 ? rd1_p1[WIDTH-1:0]       : rd0_p1[WIDTH-1:0];

`ifdef FFT_REORDER_OUTREG_EN
    logic                    vld_p2, last_p2;
    logic [N-1:0]            idx_p2;
    logic signed [WIDTH-1:0] re_p2, im_p2;

    assign take_p1 = !vld_p2 || out_ready;

    // Stage p2: output register, refilled whenever it is empty or being consumed
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            vld_p2  <= 1'b0;
            idx_p2  <= '0;
            last_p2 <= 1'b0;
        end else if (take_p1) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                idx_p2  <= idx_p1;
                last_p2 <= last_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_p1 && vld_p1) begin
            re_p2 <= re_p1;
            im_p2 <= im_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_idx   = idx_p2;
    assign out_last  = last_p2;
    assign out_re    = vld_p2 ? re_p2 : '0;
    assign out_im    = vld_p2 ? im_p2 : '0;
`else
    assign take_p1   = out_ready;
    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_last  = last_p1;
    assign out_re    = vld_p1 ? re_p1 : '0;
    assign out_im    = vld_p1 ? im_p1 : '0;
`endif

    assign busy = (|full) || (state == READ) || out_valid;

endmodule
